// File: rtl/gf_pkg.sv
// Shared definitions for the GF(2^m) inverse / S-box engine.
// Mode codes, AES constants, affine helpers and the FSM state type.
package gf_pkg;

    localparam logic [1:0] MODE_INV      = 2'd0;
    localparam logic [1:0] MODE_FWD_SBOX = 2'd1;
    localparam logic [1:0] MODE_INV_SBOX = 2'd2;
    localparam logic [1:0] MODE_MUL      = 2'd3;

    localparam logic [8:0] AES_POLY     = 9'h11B;
    localparam logic [7:0] AFFINE_C     = 8'h63;
    localparam logic [7:0] INV_AFFINE_C = 8'h05;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SQR,
        S_MULA,
        S_MULT,
        S_HOLD
    } state_t;

    function automatic logic [7:0] rotl8(
        input logic [7:0] v,
        input int unsigned n
    );
        logic [15:0] w;
        w = {v, v} << n;
        return w[15:8];
    endfunction

    // Forward AES affine: b ^ rotl1 ^ rotl2 ^ rotl3 ^ rotl4 ^ 0x63.
    function automatic logic [7:0] affine(input logic [7:0] b);
        return b ^ rotl8(b, 1) ^ rotl8(b, 2) ^ rotl8(b, 3)
                 ^ rotl8(b, 4) ^ AFFINE_C;
    endfunction

    // Inverse AES affine: rotl1 ^ rotl3 ^ rotl6 ^ 0x05.
    function automatic logic [7:0] inv_affine(input logic [7:0] s);
        return rotl8(s, 1) ^ rotl8(s, 3) ^ rotl8(s, 6) ^ INV_AFFINE_C;
    endfunction

endpackage

// File: rtl/gf_mul_mod.sv
// Combinational GF(2^WIDTH) multiplier.
// Carry-less product followed by reduction modulo POLY.
module gf_mul_mod
    import gf_pkg::*;
#(
    parameter int unsigned     WIDTH = 8,
    parameter logic [WIDTH:0]  POLY  = AES_POLY
) (
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    output logic [WIDTH-1:0] p
);

    localparam int unsigned PW = 2 * WIDTH - 1;

    logic [PW-1:0] prod;
    logic [PW-1:0] red;

    // Carry-less (XOR) partial-product accumulation.
    always_comb begin
        prod = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (y[i]) begin
                prod = prod ^ (PW'(x) << i);
            end
        end
    end

    // Clear high bits from the top down by XORing shifted POLY.
    always_comb begin
        red = prod;
        for (int i = PW - 1; i >= int'(WIDTH); i--) begin
            if (red[i]) begin
                red = red ^ (PW'(POLY) << (i - int'(WIDTH)));
            end
        end
        p = red[WIDTH-1:0];
    end

endmodule

// File: rtl/gf_inverse_engine.sv
// Sequential GF(2^WIDTH) inverse / S-box / multiply engine.
// One shared multiplier; inverse via a^(2^m-2) square-and-multiply.
module gf_inverse_engine
    import gf_pkg::*;
#(
    parameter int unsigned     WIDTH = 8,
    parameter logic [WIDTH:0]  POLY  = AES_POLY
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_mode,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_err,
    output logic             busy
);

    localparam int unsigned KW     = $clog2(WIDTH);
    localparam logic [KW-1:0] K_INIT = KW'(WIDTH - 1);
    localparam bit          IS_AES = (WIDTH == 8);

    state_t           state_q, state_d;
    logic [1:0]       mode_q, mode_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic [KW-1:0]    k_q, k_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic             out_err_q, out_err_d;

    logic [WIDTH-1:0] mul_x, mul_y, mul_p;
    logic [WIDTH-1:0] a_pre;
    logic [WIDTH-1:0] fwd_res;
    logic             sbox_mode;

    gf_mul_mod #(
        .WIDTH (WIDTH),
        .POLY  (POLY)
    ) u_mul (
        .x (mul_x),
        .y (mul_y),
        .p (mul_p)
    );

    // Affine steps only exist for the 8-bit AES field; bypass otherwise.
    if (IS_AES) begin : g_aes
        assign a_pre   = WIDTH'(inv_affine(8'(in_a)));
        assign fwd_res = WIDTH'(affine(8'(mul_p)));
    end else begin : g_plain
        assign a_pre   = in_a;
        assign fwd_res = mul_p;
    end

    assign sbox_mode = (mode_q == MODE_FWD_SBOX) ||
                       (mode_q == MODE_INV_SBOX);

    // Multiplier operand select: r*r, r*a or a*b depending on state.
    always_comb begin
        mul_x = r_q;
        mul_y = r_q;
        unique case (state_q)
            S_MULA: mul_y = a_q;
            S_MULT: begin
                mul_x = a_q;
                mul_y = b_q;
            end
            default: ;
        endcase
    end

    // Next-state and datapath updates for the exponentiation FSM.
    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        a_d        = a_q;
        b_d        = b_q;
        r_d        = r_q;
        k_d        = k_q;
        out_data_d = out_data_q;
        out_err_d  = out_err_q;
        unique case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    mode_d  = in_mode;
                    b_d     = in_b;
                    a_d     = (in_mode == MODE_INV_SBOX) ? a_pre : in_a;
                    r_d     = WIDTH'(1);
                    k_d     = K_INIT;
                    state_d = (in_mode == MODE_MUL) ? S_MULT : S_SQR;
                end
            end
            S_SQR: begin
                r_d = mul_p;
                if (k_q == '0) begin
                    state_d    = S_HOLD;
                    out_data_d = (mode_q == MODE_FWD_SBOX) ? fwd_res : mul_p;
                    out_err_d  = sbox_mode && !IS_AES;
                end else begin
                    state_d = S_MULA;
                end
            end
            S_MULA: begin
                r_d     = mul_p;
                k_d     = k_q - KW'(1);
                state_d = S_SQR;
            end
            S_MULT: begin
                out_data_d = mul_p;
                out_err_d  = 1'b0;
                state_d    = S_HOLD;
            end
            S_HOLD: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State registers with synchronous reset discarding any request.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            mode_q     <= MODE_INV;
            a_q        <= '0;
            b_q        <= '0;
            r_q        <= '0;
            k_q        <= '0;
            out_data_q <= '0;
            out_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            a_q        <= a_d;
            b_q        <= b_d;
            r_q        <= r_d;
            k_q        <= k_d;
            out_data_q <= out_data_d;
            out_err_q  <= out_err_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign busy      = (state_q != S_IDLE);
    assign out_valid = (state_q == S_HOLD);
    assign out_data  = out_data_q;
    assign out_err   = out_err_q;

endmodule

// File: tb/tb_gf_inverse_engine.sv
// Self-checking bench for gf_inverse_engine at WIDTH=8 and WIDTH=4.
// Reference values come from a brute-force field model.
module tb_gf_inverse_engine;

    logic       clk = 1'b0;
    logic       rst = 1'b1;

    logic       iv8 = 0, ir8, ov8, or8 = 0, oe8, busy8;
    logic [1:0] md8 = 0;
    logic [7:0] ia8 = 0, ib8 = 0, od8;

    logic       iv4 = 0, ir4, ov4, or4 = 0, oe4, busy4;
    logic [1:0] md4 = 0;
    logic [3:0] ia4 = 0, ib4 = 0, od4;

    int nvec = 0;
    int nerr = 0;

    int sbox_ref [256];
    int isbox_ref[256];

    always #5 clk = ~clk;

    gf_inverse_engine #(.WIDTH(8), .POLY(9'h11B)) dut8 (
        .clk(clk), .rst(rst),
        .in_valid(iv8), .in_ready(ir8), .in_mode(md8),
        .in_a(ia8), .in_b(ib8),
        .out_valid(ov8), .out_ready(or8), .out_data(od8),
        .out_err(oe8), .busy(busy8)
    );

    gf_inverse_engine #(.WIDTH(4), .POLY(5'h13)) dut4 (
        .clk(clk), .rst(rst),
        .in_valid(iv4), .in_ready(ir4), .in_mode(md4),
        .in_a(ia4), .in_b(ib4),
        .out_valid(ov4), .out_ready(or4), .out_data(od4),
        .out_err(oe4), .busy(busy4)
    );

    // Shift-and-add field multiply (xtime style).
    function automatic int ref_mul(input int w, input int poly,
                                   input int a, input int b);
        int r = 0;
        int aa = a;
        for (int i = 0; i < w; i++) begin
            if ((b >> i) & 1) r ^= aa;
            aa <<= 1;
            if ((aa >> w) & 1) aa ^= poly;
        end
        return r;
    endfunction

    // Inverse by exhaustive search; 0 maps to 0.
    function automatic int ref_inv(input int w, input int poly, input int a);
        if (a == 0) return 0;
        for (int x = 1; x < (1 << w); x++)
            if (ref_mul(w, poly, a, x) == 1) return x;
        return -1;
    endfunction

    // Affine map from the bitwise rule with indices mod 8.
    function automatic int ref_aff(input int b);
        int s = 0;
        int c = 'h63;
        for (int i = 0; i < 8; i++) begin
            int bit_v;
            bit_v = ((b >> i) ^ (b >> ((i + 4) % 8)) ^ (b >> ((i + 5) % 8))
                    ^ (b >> ((i + 6) % 8)) ^ (b >> ((i + 7) % 8))
                    ^ (c >> i)) & 1;
            s |= bit_v << i;
        end
        return s;
    endfunction

    task automatic check(input string tag, input int obs, input int exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Issue one request, wait for out_valid, optionally release it.
    task automatic req(input bit w4, input logic [1:0] m,
                       input int a, input int b, input bit rel,
                       output int d, output int e, output int lat);
        @(negedge clk);
        if (w4) begin
            iv4 = 1; md4 = m; ia4 = 4'(a); ib4 = 4'(b);
        end else begin
            iv8 = 1; md8 = m; ia8 = 8'(a); ib8 = 8'(b);
        end
        @(posedge clk);
        @(negedge clk);
        iv4 = 0;
        iv8 = 0;
        lat = 0;
        while (!(w4 ? ov4 : ov8) && lat < 60) begin
            @(negedge clk);
            lat++;
        end
        d = w4 ? int'(od4) : int'(od8);
        e = w4 ? int'(oe4) : int'(oe8);
        if (rel) begin
            if (w4) or4 = 1; else or8 = 1;
            @(negedge clk);
            or4 = 0;
            or8 = 0;
        end
    endtask

    initial begin
        int d, e, lat, x, y, held;

        for (int i = 0; i < 256; i++) begin
            sbox_ref[i] = ref_aff(ref_inv(8, 'h11B, i));
            isbox_ref[sbox_ref[i]] = i;
        end

        repeat (2) @(negedge clk);
        rst = 0;
        check("rst_in_ready", ir8, 1);
        check("rst_out_valid", ov8, 0);
        check("rst_out_data", od8, 0);
        check("rst_out_err", oe8, 0);
        check("rst_busy", busy8, 0);

        req(0, 2'd3, 'h57, 'h83, 1, d, e, lat);
        check("mul_57_83", d, 'hC1);
        check("mul_err", e, 0);
        check("mul_latency", lat, 1);

        req(0, 2'd1, 'h53, 0, 1, d, e, lat);
        check("fwd_53", d, 'hED);
        check("fwd_latency", lat, 15);
        check("fwd_err", e, 0);
        req(0, 2'd0, 'h53, 0, 1, d, e, lat);
        check("inv_53", d, 'hCA);
        check("inv_latency", lat, 15);
        req(0, 2'd1, 'h00, 0, 1, d, e, lat);
        check("fwd_00", d, 'h63);
        req(0, 2'd2, 'hED, 0, 1, d, e, lat);
        check("isb_ED", d, 'h53);
        check("isb_latency", lat, 15);
        req(0, 2'd2, 'h63, 0, 1, d, e, lat);
        check("isb_63", d, 'h00);
        check("post_release_ready", ir8, 1);

        for (int i = 0; i < 256; i++) begin
            req(0, 2'd1, i, 0, 1, d, e, lat);
            check("sweep_fwd", d, sbox_ref[i]);
            req(0, 2'd2, d, 0, 1, y, e, lat);
            check("sweep_isb", y, i);
        end

        for (int i = 0; i < 24; i++) begin
            x = int'($urandom_range(0, 255));
            req(0, 2'd0, x, 0, 1, d, e, lat);
            check("rand_inv", d, ref_inv(8, 'h11B, x));
            req(0, 2'd0, d, 0, 1, y, e, lat);
            check("inv_inv", y, x);
        end

        for (int i = 0; i < 40; i++) begin
            x = int'($urandom_range(0, 255));
            y = int'($urandom_range(0, 255));
            req(0, 2'd3, x, y, 1, d, e, lat);
            check("rand_mul", d, ref_mul(8, 'h11B, x, y));
        end

        req(0, 2'd1, 'hC3, 0, 0, d, e, lat);
        check("bp_result", d, sbox_ref['hC3]);
        held = d;
        for (int c = 0; c < 5; c++) begin
            if (c == 1) begin
                iv8 = 1; md8 = 2'd3; ia8 = 8'h11; ib8 = 8'h22;
            end
            @(negedge clk);
            iv8 = 0;
            check("bp_stable", od8, held);
            check("bp_valid", ov8, 1);
            check("bp_in_ready", ir8, 0);
        end
        or8 = 1;
        @(negedge clk);
        or8 = 0;
        check("bp_valid_drop", ov8, 0);
        check("bp_ready_back", ir8, 1);
        check("bp_not_busy", busy8, 0);

        @(negedge clk);
        iv8 = 1; md8 = 2'd0; ia8 = 8'h53;
        @(posedge clk);
        @(negedge clk);
        iv8 = 0;
        repeat (6) @(negedge clk);
        check("mid_busy", busy8, 1);
        rst = 1;
        @(negedge clk);
        rst = 0;
        check("mid_rst_valid", ov8, 0);
        check("mid_rst_data", od8, 0);
        check("mid_rst_busy", busy8, 0);
        check("mid_rst_ready", ir8, 1);
        req(0, 2'd0, 'h01, 0, 1, d, e, lat);
        check("after_rst_inv", d, 'h01);

        req(1, 2'd0, 'h2, 0, 1, d, e, lat);
        check("w4_inv_2", d, 'h9);
        check("w4_latency", lat, 7);
        check("w4_inv_err", e, 0);
        req(1, 2'd1, 'h2, 0, 1, d, e, lat);
        check("w4_fwd_2", d, 'h9);
        check("w4_fwd_err", e, 1);
        req(1, 2'd2, 'h2, 0, 1, d, e, lat);
        check("w4_isb_2", d, 'h9);
        check("w4_isb_err", e, 1);
        for (int i = 0; i < 16; i++) begin
            req(1, 2'd0, i, 0, 1, d, e, lat);
            check("w4_inv_sweep", d, ref_inv(4, 'h13, i));
        end
        for (int i = 0; i < 12; i++) begin
            x = int'($urandom_range(0, 15));
            y = int'($urandom_range(0, 15));
            req(1, 2'd3, x, y, 1, d, e, lat);
            check("w4_mul", d, ref_mul(4, 'h13, x, y));
            check("w4_mul_err", e, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
